// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared constants and helpers for the LED matrix scanner.
//   DEF_ROWS/DEF_COLS/DEF_DIV/DEF_BLANK : default geometry and slot timing
//   MAX_ROWS                            : widest one-hot row vector supported
//   idx_w()                             : width of an index into n items (min 1)
//   onehot()                            : one-hot decode of a row index
package led_matrix_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_DIV   = 10;
  localparam int DEF_BLANK = 1;
  localparam int MAX_ROWS  = 64;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_ROWS-1:0] onehot(input int unsigned i);
    logic [MAX_ROWS-1:0] v;
    v = '0;
    if (i < MAX_ROWS) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_scan_prescaler.sv
// led_scan_prescaler: slot counter (cnt, 0..DIV-1) and row index (idx).
// Optional feature macro: LED_MATRIX_BRIGHT_EN (adds bright input, dark output).
// Ports:
//   clk, rst    : clock, async active-low reset
//   bright      : lit cycles per slot after blanking (macro only)
//   dark        : cnt has passed the brightness window (macro only)
//   idx         : current row index
//   slot_wrap   : last cycle of a row slot (cnt == DIV-1)
//   frame_wrap  : last cycle of the last row slot (frame boundary)
//   blank       : cnt is inside the leading blanking gap
module led_scan_prescaler
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int DIV   = DEF_DIV,
  parameter int BLANK = DEF_BLANK
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef LED_MATRIX_BRIGHT_EN
  input  logic [$clog2(DIV+1)-1:0]   bright,
  output logic                       dark,
`endif
  output logic [idx_w(ROWS)-1:0]     idx,
  output logic                       slot_wrap,
  output logic                       frame_wrap,
  output logic                       blank
);

  localparam int IW = idx_w(ROWS);
  localparam int CW = idx_w(DIV);

  logic [CW-1:0] cnt;

  assign slot_wrap  = (cnt == CW'(DIV - 1));
  assign frame_wrap = slot_wrap && (idx == IW'(ROWS - 1));
  assign blank      = (int'(cnt) < BLANK);

`ifdef LED_MATRIX_BRIGHT_EN
  assign dark = (int'(cnt) >= BLANK + int'(bright));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= frame_wrap ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-scanned LED matrix driver with a double-buffered image.
// Optional feature macro: LED_MATRIX_BRIGHT_EN (adds bright input for PWM dimming).
// Ports:
//   clk, rst      : clock, async active-low reset
//   wr_en/wr_row/wr_data : write one row of the back buffer
//   swap_req      : request a buffer swap at the next frame boundary
//   bright        : lit cycles per slot after blanking (macro only)
//   swap_pending  : swap requested but not yet performed
//   frame_start   : pulse on the first output cycle of each row-0 slot
//   row_sel       : one-hot active-high row drive
//   col_data      : active-high column drive
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int DIV   = DEF_DIV,
  parameter int BLANK = DEF_BLANK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [idx_w(ROWS)-1:0]     wr_row,
  input  logic [COLS-1:0]            wr_data,
  input  logic                       swap_req,
`ifdef LED_MATRIX_BRIGHT_EN
  input  logic [$clog2(DIV+1)-1:0]   bright,
`endif
  output logic                       swap_pending,
  output logic                       frame_start,
  output logic [ROWS-1:0]            row_sel,
  output logic [COLS-1:0]            col_data
);

  localparam int IW = idx_w(ROWS);

  logic [IW-1:0]   idx;
  logic            slot_wrap;
  logic            frame_wrap;
  logic            blank;
  logic            lit;
  logic            front_sel;
  logic            slot_head;
  logic [COLS-1:0] frame_buf [2][ROWS];

`ifdef LED_MATRIX_BRIGHT_EN
  logic dark;
`endif

  led_scan_prescaler #(
    .ROWS  (ROWS),
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
`ifdef LED_MATRIX_BRIGHT_EN
    .bright     (bright),
    .dark       (dark),
`endif
    .idx        (idx),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap),
    .blank      (blank)
  );

`ifdef LED_MATRIX_BRIGHT_EN
  assign lit = !blank && !dark;
`else
  assign lit = !blank;
`endif

  // The back buffer is always the one not selected for display; a write on
  // the swap edge still targets it and so becomes the new front image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          frame_buf[b][r] <= '0;
    end else if (wr_en && (int'(wr_row) < ROWS)) begin
      frame_buf[~front_sel][wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_wrap && (swap_pending || swap_req)) begin
      front_sel    <= ~front_sel;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  // slot_head mirrors cnt==0: set out of reset and after every slot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_head   <= 1'b1;
      frame_start <= 1'b0;
      row_sel     <= '0;
      col_data    <= '0;
    end else begin
      slot_head   <= slot_wrap;
      frame_start <= slot_head && (idx == '0);
      if (lit) begin
        row_sel  <= ROWS'(onehot(32'(idx)));
        col_data <= frame_buf[front_sel][idx];
      end else begin
        row_sel  <= '0;
        col_data <= '0;
      end
    end
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Parametrised row-scanned LED matrix driver; the successor to the fixed 8x8 scanner.
- Holds a double-buffered frame image with ROWS rows of COLS bits each. Host logic writes the back buffer and requests a swap.
- The scanner walks rows at a prescaled rate, inserts a blanking gap at the start of each row slot, and swaps buffers only at a frame boundary, so the display never tears.
- Sits between host/pattern logic and the matrix row/column pins.

Parameters:
- ROWS, 8, number of matrix rows (>=2).
- COLS, 8, number of matrix columns (>=1).
- DIV, 10, clk cycles per row slot (>=2).
- BLANK, 1, cycles at the start of each slot with all outputs off (0 <= BLANK < DIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe into the back buffer.
- wr_row  in  $clog2(ROWS)  back-buffer row address.
- wr_data  in  COLS  row pixel data; bit c = column c, 1 = lit.
- swap_req  in  1  single-cycle request to swap buffers at the next frame boundary.
- swap_pending  out  1  request latched, swap not yet performed.
- frame_start  out  1  one-cycle pulse marking the first cycle of each row-0 slot.
- row_sel  out  ROWS  one-hot active-high row drive.
- col_data  out  COLS  active-high column drive.

Behaviour:
- Reset (rst=0, async):
  - Slot counter cnt=0, row index idx=0.
  - Both buffers cleared; front-select=0; swap_pending=0.
  - row_sel=0, col_data=0, frame_start=0.
- Prescaler:
  - cnt counts 0..DIV-1, then wraps to 0.
  - When cnt==DIV-1, idx advances: idx==ROWS-1 wraps to 0, otherwise idx+1.
- Outputs are registered and lag the internal counter state by exactly one cycle.
- Within a slot:
  - While cnt<BLANK: row_sel=0, col_data=0.
  - Otherwise: row_sel=one-hot(idx), col_data=front[idx].
- frame_start:
  - High for the output cycle corresponding to cnt==0, idx==0.
  - The first pulse occurs on the first clock edge after reset release.
  - Period is exactly ROWS*DIV cycles.
- Writes:
  - wr_en=1 writes wr_data to back[wr_row] on that edge.
  - wr_row>=ROWS: write ignored.
  - The front buffer is never host-writable.
- Swap:
  - swap_req=1 sets swap_pending.
  - A further swap_req while pending has no effect; there is no queueing.
  - The frame boundary is the edge where cnt==DIV-1 and idx==ROWS-1.
  - At the boundary, if swap_pending (or swap_req asserted on that same edge): front-select toggles and swap_pending clears.
  - The new image is first visible in the next row-0 slot.
- Simultaneous events:
  - A write on the swap edge lands in the pre-swap back buffer, so it is displayed.
  - swap_req on the swap edge is consumed by that swap; swap_pending stays 0.
- Reset mid-frame: immediate return to the reset state; frame contents are lost.

Optional Feature:
- LED_MATRIX_BRIGHT_EN defined:
  - Adds input port bright, width $clog2(DIV+1).
  - In the non-blank part of a slot, outputs are driven only while cnt < BLANK+bright; the remainder of the slot is off.
  - bright>=DIV-BLANK gives full on; bright=0 gives dark.
- LED_MATRIX_BRIGHT_EN undefined: no bright port; behaviour is full on.

Decomposition:
- Package led_matrix_pkg holds:
  - Default ROWS/COLS/DIV/BLANK constants.
  - An index-width helper function.
  - A one-hot decode function.
- Sub-module led_scan_prescaler: owns cnt and idx and emits slot_wrap, frame_wrap and blank.
- The top level owns both buffers, swap logic and output registers.

Test Plan (ROWS=8, COLS=8, DIV=10, BLANK=2):
- Reset, then release → row_sel=0 and col_data=0 during reset. frame_start pulses 1 cycle after release, then every 80 cycles.
- Write back[3]=8'hA5, swap_req, run two frames → row 3 slot shows col_data=8'hA5 for 8 cycles after 2 blank cycles. Other rows show 0. row_sel=8'h08 during that slot.
- swap_req mid-frame → swap_pending=1 until the frame boundary, then 0. Old image holds until the next frame_start.
- swap_req and wr_en(row 0, 8'hFF) on the frame-boundary edge → swap occurs, swap_pending stays 0, next row-0 slot shows 8'hFF.
- Assert rst during row 5 → outputs are 0 immediately. After release, both buffers are cleared and the first frame_start pulse follows.
- With LED_MATRIX_BRIGHT_EN and bright=3 → per slot: 2 blank cycles, 3 lit cycles, 5 off cycles. bright=8 → 8 lit cycles.
